fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-request-deep bus fetch with a one-entry hold buffer for decode stalls.
// Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        flush,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] inst_code,
    output logic [31:0] pc_addr,
    output logic        inst_valid,
    output logic        exc_adel
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD, S_ERR} state_t;

    state_t      state, state_nxt;
    logic        active;
    logic [31:0] fetch_pc;
    logic [31:0] disc_addr;
    logic [31:0] hold_code;
    logic [31:0] hold_pc;
    logic [31:0] redir_pc;
    logic        redir_bad;
    logic        xfer;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad = (redirect_addr[1:0] != 2'b00);
    assign redir_pc  = redirect_addr;
`else
    assign redir_bad = 1'b0;
    assign redir_pc  = {redirect_addr[31:2], 2'b00};
`endif

    assign xfer = ibus_req & ibus_ack;

    // active stays low for the first cycle after reset so a stale ack is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!active) begin
            state_nxt = S_REQ;
        end else if (redirect) begin
            if (redir_bad)
                state_nxt = S_ERR;
            else if ((state == S_REQ || state == S_DISCARD) && !xfer)
                state_nxt = S_DISCARD;   // outstanding request must still complete
            else
                state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ:     if (xfer && stall && !flush) state_nxt = S_HOLD;
                S_HOLD:    if (!stall || flush) state_nxt = S_REQ;
                S_DISCARD: if (xfer) state_nxt = S_REQ;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        ibus_req  = active && (state == S_REQ || state == S_DISCARD);
        ibus_addr = (state == S_DISCARD) ? disc_addr : fetch_pc;
    end

    // Flush wins over a coincident ack: the bus beat retires and fetch_pc advances,
    // but its word is not presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            disc_addr  <= 32'd0;
            hold_code  <= 32'd0;
            hold_pc    <= 32'd0;
            inst_code  <= 32'd0;
            pc_addr    <= 32'd0;
            inst_valid <= 1'b0;
        end else if (active) begin
            if (redirect) begin
                inst_valid <= 1'b0;
                fetch_pc   <= redir_pc;
                if (state == S_REQ && !xfer)
                    disc_addr <= fetch_pc;
                if (redir_bad)
                    pc_addr <= redirect_addr;
            end else begin
                if (xfer && state == S_REQ)
                    fetch_pc <= pc_inc(fetch_pc);
                if (flush) begin
                    inst_valid <= 1'b0;
                end else if (state == S_REQ && xfer && !stall) begin
                    inst_code  <= ibus_rdata;
                    pc_addr    <= fetch_pc;
                    inst_valid <= 1'b1;
                end else if (state == S_REQ && xfer && stall) begin
                    hold_code <= ibus_rdata;
                    hold_pc   <= fetch_pc;
                end else if (state == S_HOLD && !stall) begin
                    inst_code  <= hold_code;
                    pc_addr    <= hold_pc;
                    inst_valid <= 1'b1;
                end else if (!stall) begin
                    inst_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic adel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            adel <= 1'b0;
        else if (active && redirect)
            adel <= redir_bad;
    end

    assign exc_adel = adel;
`else
    assign exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC00000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'd0;
    logic        flush = 1'b0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = 32'd0;
    logic [31:0] inst_code;
    logic [31:0] pc_addr;
    logic        inst_valid;
    logic        exc_adel;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .flush(flush), .ibus_req(ibus_req),
        .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .inst_code(inst_code), .pc_addr(pc_addr), .inst_valid(inst_valid),
        .exc_adel(exc_adel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct { logic [31:0] pc; logic [31:0] code; } ent_t;

    // Model: words waiting for decode, addresses whose data will be thrown away.
    ent_t        hold_q[$];
    logic [31:0] drop_q[$];
    bit          m_active, m_err, m_valid, m_adel;
    logic [31:0] m_pc, m_code, m_pcaddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hold_q.delete();
        drop_q.delete();
        m_active = 0; m_err = 0; m_valid = 0; m_adel = 0;
        m_pc = RST_PC; m_code = 0; m_pcaddr = 0;
    endtask

    function automatic bit exp_req();
        return m_active && !m_err && hold_q.size() == 0;
    endfunction

    function automatic logic [31:0] exp_addr();
        return (drop_q.size() != 0) ? drop_q[0] : m_pc;
    endfunction

    task automatic model_step();
        bit   req, x, have;
        ent_t got;
        req  = exp_req();
        x    = req && ibus_ack;
        have = 0;
        if (!m_active) begin
            m_active = 1;
        end else if (redirect) begin
            m_valid = 0;
            hold_q.delete();
            if (drop_q.size() != 0) begin
                if (x) drop_q.delete();
            end else if (req && !x) begin
                drop_q.push_back(m_pc);
            end
            if (ALIGN && redirect_addr[1:0] != 2'b00) begin
                m_err = 1; m_adel = 1; m_pcaddr = redirect_addr;
                drop_q.delete();
            end else begin
                m_err = 0; m_adel = 0;
                m_pc = {redirect_addr[31:2], 2'b00};
            end
        end else begin
            if (x && drop_q.size() != 0) begin
                drop_q.delete();
            end else if (x) begin
                have = 1; got.pc = m_pc; got.code = ibus_rdata;
                m_pc = m_pc + 32'd4;
            end
            if (flush) begin
                m_valid = 0;
                hold_q.delete();
            end else if (!stall) begin
                if (hold_q.size() != 0) begin
                    got = hold_q.pop_front();
                    have = 1;
                end
                if (have) begin
                    m_valid = 1; m_code = got.code; m_pcaddr = got.pc;
                end else begin
                    m_valid = 0;
                end
            end else if (have) begin
                hold_q.push_back(got);
            end
        end
    endtask

    task automatic cycle();
        #1;
        chk("ibus_req", {31'd0, ibus_req}, {31'd0, exp_req()});
        if (exp_req()) chk("ibus_addr", ibus_addr, exp_addr());
        model_step();
        @(posedge clk);
        #1;
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("pc_addr", pc_addr, m_pcaddr);
        chk("inst_code", inst_code, m_code);
        chk("exc_adel", {31'd0, exc_adel}, {31'd0, m_adel});
    endtask

    task automatic drive(input bit s, input bit rd, input logic [31:0] ra,
                         input bit fl, input bit ack, input logic [31:0] data);
        stall = s; redirect = rd; redirect_addr = ra; flush = fl;
        ibus_ack = ack; ibus_rdata = data;
    endtask

    task automatic reset_checks();
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc", pc_addr, 32'd0);
        chk("rst_code", inst_code, 32'd0);
        chk("rst_req", {31'd0, ibus_req}, 32'd0);
        chk("rst_adel", {31'd0, exc_adel}, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks();

        // Release with a stale ack: it must be ignored.
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h11111111);
        cycle();

        // Back-to-back fetches.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 32'h24010001);
            #1 chk("seq_addr", ibus_addr, RST_PC + 32'(4 * i));
            cycle();
        end
        chk("seq_valid", {31'd0, inst_valid}, 32'd1);
        chk("seq_pc", pc_addr, RST_PC + 32'd4);

        // Ack under stall parks the word, then releases it.
        drive(1, 0, 0, 0, 1, 32'hA5A50008);
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1, 32'h0);
            cycle();
            chk("hold_req", {31'd0, ibus_req}, 32'd0);
            chk("hold_pc", pc_addr, RST_PC + 32'd4);
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("unhold_pc", pc_addr, 32'hBFC00008);
        chk("unhold_code", inst_code, 32'hA5A50008);
        chk("next_addr", ibus_addr, 32'hBFC0000C);

        // Redirect while a request is pending: its data must be dropped.
        drive(0, 1, 32'h80000100, 0, 0, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("disc_addr", ibus_addr, 32'hBFC0000C);
        drive(0, 0, 0, 0, 1, 32'hDEADBEEF);
        cycle();
        total++;
        assert (inst_code !== 32'hDEADBEEF) else begin
            bad++;
            $error("FAIL discard_code observed=%h expected=not DEADBEEF", inst_code);
        end
        chk("redir_addr", ibus_addr, 32'h80000100);

        // Wrap of the fetch address.
        drive(0, 1, 32'hFFFFFFFC, 0, 1, 32'h0);
        cycle();
        chk("wrap_pre", ibus_addr, 32'hFFFFFFFC);
        drive(0, 0, 0, 0, 1, 32'h12345678);
        cycle();
        chk("wrap_addr", ibus_addr, 32'h00000000);
        chk("wrap_pc", pc_addr, 32'hFFFFFFFC);

`ifdef FETCH_ALIGN_CHECK_EN
        drive(0, 1, 32'h80000102, 0, 0, 32'h0);
        cycle();
        chk("adel_set", {31'd0, exc_adel}, 32'd1);
        chk("adel_req", {31'd0, ibus_req}, 32'd0);
        drive(0, 1, 32'h80000180, 0, 0, 32'h0);
        cycle();
        chk("adel_clr", {31'd0, exc_adel}, 32'd0);
        chk("adel_addr", ibus_addr, 32'h80000180);
`endif

        // Flush with a parked word.
        drive(1, 0, 0, 0, 1, 32'h0BADF00D);
        cycle();
        drive(1, 0, 0, 1, 0, 32'h0);
        cycle();
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);

        // Reset during a pending request.
        drive(0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h22222222);
        cycle();
        chk("rr_addr", ibus_addr, RST_PC);
        drive(0, 0, 0, 0, 0, 32'h0);
        cycle();
        chk("rr_valid", {31'd0, inst_valid}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFF0 | (ra & 32'hF);
            if (ALIGN && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, ra,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, $urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
